col_pad_axis: RTL

//  Parametrised horizontal (column) border padder for AXI4-Stream pixel rows. Each

---
 rtl/col_pad_axis.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/col_pad_axis.sv
// Horizontal border padder for AXI4-Stream pixel lines: each line of W pixels leaves
// as W+2*PAD pixels with zero, edge-replicate or mirror borders.
module col_pad_axis #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int PAD         = 2,
  parameter int PAD_MODE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic                   err_short
);
  localparam int CW = 4;
  localparam int AW = (PAD + 1 > 1) ? $clog2(PAD + 1) : 1;
  localparam logic [CW-1:0] PADC  = CW'(PAD);
  localparam logic [15:0]   PAD16 = 16'(PAD);

  typedef enum logic [1:0] {S_FILL, S_LEFT, S_BODY, S_RIGHT} state_t;

  state_t                   state_q, state_d;
  logic [TDATA_WIDTH-1:0]   win_q  [0:PAD];
  logic [TDATA_WIDTH-1:0]   win_d  [0:PAD];
  logic [TDATA_WIDTH-1:0]   hist_q [0:PAD];
  logic [TDATA_WIDTH-1:0]   hist_d [0:PAD];
  logic [CW-1:0]            bcnt_q, bcnt_d, pcnt_q, pcnt_d;
  logic [15:0]              pix_q, pix_d;
  logic                     got_last_q, got_last_d;
  logic [TUSER_WIDTH-1:0]   user_q, user_d;
  logic [TDEST_WIDTH-1:0]   dest_q, dest_d;
  logic                     m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [TDATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [TUSER_WIDTH-1:0]   m_user_q, m_user_d;
  logic [TDEST_WIDTH-1:0]   m_dest_q, m_dest_d;
  logic                     err_q, err_d;

  logic                     load, s_hs, pop;
  logic [CW-1:0]            cnt_after, pidx;
  logic [TDATA_WIDTH-1:0]   lval, rval;

  // Output register can take a new beat when empty or being drained this cycle.
  assign load          = !m_valid_q || m_axis_tready;
  assign s_axis_tready = !rst && ((state_q == S_FILL) ||
                                  (state_q == S_BODY && !got_last_q && load));
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tdest  = m_dest_q;
  assign err_short     = err_q;

  // Left pad reads the fill window (x[0..PAD]); right pad reads the history of the
  // last emitted body pixels, hist[k] = x[W-1-k].
  always_comb begin
    pidx = (pcnt_q > PADC) ? PADC : pcnt_q;
    case (PAD_MODE)
      0: begin lval = '0;       rval = '0;        end
      1: begin lval = win_q[0]; rval = hist_q[0]; end
      default: begin
        lval = win_q[AW'(pidx)];
        rval = hist_q[AW'(pidx)];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    hist_d     = hist_q;
    bcnt_d     = bcnt_q;
    pcnt_d     = pcnt_q;
    pix_d      = pix_q;
    got_last_d = got_last_q;
    user_d     = user_q;
    dest_d     = dest_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    m_dest_d   = m_dest_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    cnt_after  = bcnt_q;
    if (load) m_valid_d = 1'b0;

    case (state_q)
      S_FILL: begin
        if (s_hs) begin
          if (pix_q == 16'd0) begin
            user_d = s_axis_tuser;
            dest_d = s_axis_tdest;
          end
          if (s_axis_tlast && pix_q < PAD16) begin
            err_d  = 1'b1;
            pix_d  = '0;
            bcnt_d = '0;
          end else begin
            win_d[AW'(bcnt_q)] = s_axis_tdata;
            bcnt_d = bcnt_q + CW'(1);
            pix_d  = pix_q + 16'd1;
            if (pix_q == PAD16) begin
              state_d    = S_LEFT;
              pcnt_d     = PADC;
              got_last_d = s_axis_tlast;
            end
          end
        end
      end
      S_LEFT: begin
        if (load) begin
          m_valid_d = 1'b1;
          m_data_d  = lval;
          m_last_d  = 1'b0;
          m_user_d  = (pcnt_q == PADC) ? user_q : '0;
          m_dest_d  = dest_q;
          pcnt_d    = pcnt_q - CW'(1);
          if (pcnt_q == CW'(1)) state_d = S_BODY;
        end
      end
      S_BODY: begin
        pop = load && (bcnt_q != '0);
        if (pop) begin
          m_valid_d = 1'b1;
          m_data_d  = win_q[0];
          m_last_d  = 1'b0;
          m_user_d  = '0;
          m_dest_d  = dest_q;
          for (int i = 0; i < PAD; i++) win_d[i] = win_q[i+1];
          hist_d[0] = win_q[0];
          for (int i = 1; i <= PAD; i++) hist_d[i] = hist_q[i-1];
        end
        cnt_after = bcnt_q - {{(CW-1){1'b0}}, pop};
        if (s_hs) begin
          win_d[AW'(cnt_after)] = s_axis_tdata;
          got_last_d = s_axis_tlast;
          pix_d = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
        end
        bcnt_d = cnt_after + {{(CW-1){1'b0}}, s_hs};
        if (got_last_d && bcnt_d == '0) begin
          state_d = S_RIGHT;
          pcnt_d  = CW'(1);
        end
      end
      S_RIGHT: begin
        if (pcnt_q <= PADC) begin
          if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = rval;
            m_last_d  = (pcnt_q == PADC);
            m_user_d  = '0;
            m_dest_d  = dest_q;
            pcnt_d    = pcnt_q + CW'(1);
          end
        end else if (m_valid_q && m_axis_tready) begin
          state_d    = S_FILL;
          pix_d      = '0;
          bcnt_d     = '0;
          got_last_d = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      win_q      <= '{default: '0};
      hist_q     <= '{default: '0};
      bcnt_q     <= '0;
      pcnt_q     <= '0;
      pix_q      <= '0;
      got_last_q <= 1'b0;
      user_q     <= '0;
      dest_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= '0;
      m_dest_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      hist_q     <= hist_d;
      bcnt_q     <= bcnt_d;
      pcnt_q     <= pcnt_d;
      pix_q      <= pix_d;
      got_last_q <= got_last_d;
      user_q     <= user_d;
      dest_q     <= dest_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      m_dest_q   <= m_dest_d;
      err_q      <= err_d;
    end
  end
endmodule
